// File: rtl/mc97_fifo_wm.sv
// First-word-fall-through FIFO with level, watermark interrupts and flush engine.
// Optional sticky overflow/underflow flags are built when MC97_FIFO_WM_ERR_EN is defined.
module mc97_fifo_wm #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_ena,
  output logic             wr_full,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ena,
  output logic             rd_empty,
  output logic [LW-1:0]    ctl_lvl,
  input  logic             ctl_flush,
  output logic             ctl_flush_busy,
  input  logic [LW-1:0]    cfg_wm_hi,
  input  logic [LW-1:0]    cfg_wm_lo,
  output logic             irq_hi,
  output logic             irq_lo,
  output logic             err_ovf,
  output logic             err_udf,
  input  logic             err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     ram_cnt;
  logic [LW-1:0]     lvl_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              fetch;

  // Level counts the output register too, so words still in RAM = level minus head.
  always_comb begin
    wr_acc  = wr_ena && !wr_full && (state == IDLE);
    rd_acc  = (rd_ena || (state == FLUSH)) && !rd_empty;
    ram_cnt = ctl_lvl - LW'(!rd_empty);
    fetch   = (ram_cnt != '0) && (rd_empty || rd_acc);
    lvl_nxt = ctl_lvl;
    if (wr_acc && !rd_acc) begin
      lvl_nxt = ctl_lvl + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      lvl_nxt = ctl_lvl - LW'(1);
    end
  end

  // Storage and head register; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
    if (fetch) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // Pointers, level, flags and flush FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ctl_flush_busy <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ctl_lvl        <= '0;
      rd_empty       <= 1'b1;
      wr_full        <= 1'b0;
      irq_hi         <= (cfg_wm_hi == '0);
      irq_lo         <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      ctl_lvl  <= lvl_nxt;
      rd_empty <= !(fetch || (!rd_empty && !rd_acc));
      wr_full  <= (lvl_nxt == LW'(DEPTH));
      irq_hi   <= (lvl_nxt >= cfg_wm_hi);
      irq_lo   <= (lvl_nxt <= cfg_wm_lo);
      case (state)
        IDLE: begin
          if (ctl_flush) begin
            state          <= FLUSH;
            ctl_flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          // Writes are dropped here, so a zero level means nothing is in flight.
          if (ctl_lvl == '0) begin
            state          <= IDLE;
            ctl_flush_busy <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          ctl_flush_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef MC97_FIFO_WM_ERR_EN
  // Sticky error flags; a clear takes priority over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_ena && wr_full && (state == IDLE)) begin
        err_ovf <= 1'b1;
      end
      if (rd_ena && rd_empty) begin
        err_udf <= 1'b1;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_ovf        = 1'b0;
  assign err_udf        = 1'b0;
`endif

endmodule

// File: tb/tb_mc97_fifo_wm.sv
// Randomised bench for mc97_fifo_wm against a queue-based reference model.
module tb_mc97_fifo_wm;

  localparam int DEPTH = 256;
  localparam int LW    = 9;
`ifdef MC97_FIFO_WM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_ena = 1'b0;
  logic          wr_full;
  logic [15:0]   rd_data;
  logic          rd_ena = 1'b0;
  logic          rd_empty;
  logic [LW-1:0] ctl_lvl;
  logic          ctl_flush = 1'b0;
  logic          ctl_flush_busy;
  logic [LW-1:0] cfg_wm_hi = '0;
  logic [LW-1:0] cfg_wm_lo = '0;
  logic          irq_hi;
  logic          irq_lo;
  logic          err_ovf;
  logic          err_udf;
  logic          err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  mc97_fifo_wm #(.WIDTH(16), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_ena(wr_ena), .wr_full(wr_full),
    .rd_data(rd_data), .rd_ena(rd_ena), .rd_empty(rd_empty),
    .ctl_lvl(ctl_lvl), .ctl_flush(ctl_flush), .ctl_flush_busy(ctl_flush_busy),
    .cfg_wm_hi(cfg_wm_hi), .cfg_wm_lo(cfg_wm_lo), .irq_hi(irq_hi), .irq_lo(irq_lo),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: each stored word remembers the edge that wrote it.
  typedef struct {
    logic [15:0] d;
    int          e;
  } ent_t;

  ent_t q[$];
  int   ecount = 0;
  bit   m_flush = 0;
  bit   m_ovf = 0;
  bit   m_udf = 0;
  bit   m_hi = 0;
  bit   m_lo = 1;

  // The head word is visible once at least one full edge has passed since its write.
  function automatic bit m_empty();
    return !(q.size() > 0 && q[0].e <= ecount - 1);
  endfunction

  task automatic step();
    bit   full_pre, empty_pre, wacc, racc;
    int   lvl_pre;
    ent_t n;
    lvl_pre   = q.size();
    full_pre  = (lvl_pre == DEPTH);
    empty_pre = m_empty();
    if (rst) begin
      q.delete();
      m_flush = 0;
      m_ovf   = 0;
      m_udf   = 0;
      m_hi    = (cfg_wm_hi == 0);
      m_lo    = 1;
    end else begin
      wacc = wr_ena && !full_pre && !m_flush;
      racc = (rd_ena || m_flush) && !empty_pre;
      if (ERR_EN) begin
        if (err_clr) begin
          m_ovf = 0;
          m_udf = 0;
        end else begin
          if (wr_ena && full_pre && !m_flush) m_ovf = 1;
          if (rd_ena && empty_pre) m_udf = 1;
        end
      end
      if (racc) void'(q.pop_front());
      if (wacc) begin
        n.d = wr_data;
        n.e = ecount + 1;
        q.push_back(n);
      end
      if (m_flush) begin
        if (lvl_pre == 0) m_flush = 0;
      end else if (ctl_flush) begin
        m_flush = 1;
      end
      m_hi = (q.size() >= int'(cfg_wm_hi));
      m_lo = (q.size() <= int'(cfg_wm_lo));
    end
    @(posedge clk);
    ecount++;
    #1;
  endtask

  task automatic test_reset();
    cfg_wm_hi = 9'd0;
    cfg_wm_lo = 9'd8;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (irq_hi !== 1'b1) begin fails++; $display("FAIL reset_irq_hi_wm0 got=%b exp=1", irq_hi); end
    cfg_wm_hi = 9'd64;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (ctl_lvl !== 9'd0) begin fails++; $display("FAIL reset_lvl got=%0d exp=0", ctl_lvl); end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", rd_empty); end
    tests++; if (wr_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", wr_full); end
    tests++; if (ctl_flush_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", ctl_flush_busy); end
    tests++; if (irq_lo !== 1'b1) begin fails++; $display("FAIL reset_irq_lo got=%b exp=1", irq_lo); end
    tests++; if (irq_hi !== 1'b0) begin fails++; $display("FAIL reset_irq_hi got=%b exp=0", irq_hi); end
    tests++; if ({err_ovf, err_udf} !== 2'b00) begin fails++; $display("FAIL reset_err got=%b%b exp=00", err_ovf, err_udf); end
  endtask

  task automatic test_first_word();
    wr_data = 16'h1234;
    wr_ena  = 1'b1;
    step();
    wr_ena = 1'b0;
    tests++; if (ctl_lvl !== 9'd1) begin fails++; $display("FAIL fw_lvl_n1 got=%0d exp=1", ctl_lvl); end
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("FAIL fw_empty_n1 got=%b exp=1", rd_empty); end
    step();
    tests++; if (rd_empty !== 1'b0) begin fails++; $display("FAIL fw_empty_n2 got=%b exp=0", rd_empty); end
    tests++; if (rd_data !== 16'h1234) begin fails++; $display("FAIL fw_data got=%h exp=1234", rd_data); end
    rd_ena = 1'b1;
    step();
    rd_ena = 1'b0;
    tests++; if (rd_empty !== 1'b1 || ctl_lvl !== 9'd0) begin
      fails++; $display("FAIL fw_drain empty=%b lvl=%0d exp empty=1 lvl=0", rd_empty, ctl_lvl);
    end
  endtask

  task automatic test_fill_full();
    cfg_wm_hi = 9'd64;
    cfg_wm_lo = 9'd8;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = 16'(i);
      wr_ena  = 1'b1;
      step();
      tests++; if (ctl_lvl !== 9'(i + 1) || irq_hi !== (i + 1 >= 64)) begin
        fails++; $display("FAIL fill_lvl_irq i=%0d lvl=%0d irq_hi=%b exp lvl=%0d irq_hi=%b", i, ctl_lvl, irq_hi, i + 1, i + 1 >= 64);
      end
    end
    tests++; if (wr_full !== 1'b1 || ctl_lvl !== 9'd256) begin
      fails++; $display("FAIL full_flag full=%b lvl=%0d exp full=1 lvl=256", wr_full, ctl_lvl);
    end
    wr_data = 16'hFFFF;
    step();
    wr_ena = 1'b0;
    tests++; if (ctl_lvl !== 9'd256) begin fails++; $display("FAIL ovf_lvl got=%0d exp=256", ctl_lvl); end
    tests++; if (err_ovf !== ERR_EN) begin fails++; $display("FAIL ovf_flag got=%b exp=%b", err_ovf, ERR_EN); end
    // Write and read together while full: only the read goes through.
    wr_ena  = 1'b1;
    rd_ena  = 1'b1;
    wr_data = 16'hBEEF;
    tests++; if (rd_data !== 16'h0000) begin fails++; $display("FAIL full_rw_head got=%h exp=0000", rd_data); end
    step();
    wr_ena = 1'b0;
    tests++; if (ctl_lvl !== 9'd255 || wr_full !== 1'b0) begin
      fails++; $display("FAIL full_rw lvl=%0d full=%b exp lvl=255 full=0", ctl_lvl, wr_full);
    end
    for (int i = 1; i < DEPTH; i++) begin
      tests++; if (rd_empty !== 1'b0 || rd_data !== 16'(i)) begin
        fails++; $display("FAIL readback i=%0d data=%h empty=%b exp=%h", i, rd_data, rd_empty, 16'(i));
      end
      step();
      tests++; if (irq_lo !== (DEPTH - 1 - i <= 8)) begin
        fails++; $display("FAIL drain_irq_lo lvl=%0d got=%b exp=%b", ctl_lvl, irq_lo, DEPTH - 1 - i <= 8);
      end
    end
    rd_ena = 1'b0;
    tests++; if (rd_empty !== 1'b1 || ctl_lvl !== 9'd0) begin
      fails++; $display("FAIL drain_end empty=%b lvl=%0d exp empty=1 lvl=0", rd_empty, ctl_lvl);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got=%b exp=0", err_ovf); end
  endtask

  task automatic test_underflow();
    rd_ena = 1'b1;
    step();
    tests++; if (err_udf !== ERR_EN) begin fails++; $display("FAIL udf_set got=%b exp=%b", err_udf, ERR_EN); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    rd_ena  = 1'b0;
    tests++; if (err_udf !== 1'b0) begin fails++; $display("FAIL udf_clear_wins got=%b exp=0", err_udf); end
  endtask

  task automatic test_back_to_back();
    wr_ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 16'($urandom);
      step();
    end
    wr_ena = 1'b0;
    step();
    step();
    wr_ena = 1'b1;
    rd_ena = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr_data = 16'($urandom);
      tests++; if (rd_empty !== 1'b0 || rd_data !== q[0].d) begin
        fails++; $display("FAIL b2b_data i=%0d data=%h empty=%b exp=%h", i, rd_data, rd_empty, q[0].d);
      end
      step();
      tests++; if (ctl_lvl !== 9'd10) begin fails++; $display("FAIL b2b_lvl i=%0d got=%0d exp=10", i, ctl_lvl); end
    end
    wr_ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests++; if (rd_data !== q[0].d) begin fails++; $display("FAIL b2b_tail got=%h exp=%h", rd_data, q[0].d); end
      step();
    end
    rd_ena = 1'b0;
  endtask

  task automatic test_flush();
    int busy_cycles;
    bit done;
    ctl_flush = 1'b1;
    step();
    ctl_flush = 1'b0;
    tests++; if (ctl_flush_busy !== 1'b1) begin fails++; $display("FAIL flush_empty_enter got=%b exp=1", ctl_flush_busy); end
    step();
    tests++; if (ctl_flush_busy !== 1'b0) begin fails++; $display("FAIL flush_empty_exit got=%b exp=0", ctl_flush_busy); end
    wr_ena = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = 16'($urandom);
      step();
    end
    ctl_flush = 1'b1;
    step();
    ctl_flush = 1'b0;
    busy_cycles = 0;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      wr_data = 16'($urandom);
      tests++; if (ctl_flush_busy !== m_flush) begin
        fails++; $display("FAIL flush_busy i=%0d got=%b exp=%b", i, ctl_flush_busy, m_flush);
      end
      if (ctl_flush_busy) busy_cycles++;
      else done = 1;
      if (!done) step();
    end
    wr_ena = 1'b0;
    tests++; if (!done) begin fails++; $display("FAIL flush_timeout busy=%b exp=0", ctl_flush_busy); end
    tests++; if (busy_cycles < 95 || busy_cycles > 110) begin
      fails++; $display("FAIL flush_duration got=%0d exp=95..110", busy_cycles);
    end
    step();
    tests++; if (ctl_lvl !== 9'd0 || rd_empty !== 1'b1) begin
      fails++; $display("FAIL flush_result lvl=%0d empty=%b exp lvl=0 empty=1", ctl_lvl, rd_empty);
    end
  endtask

  task automatic test_rst_in_flush();
    rd_ena = 1'b1;
    step();
    rd_ena = 1'b0;
    wr_ena = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_data = 16'($urandom);
      step();
    end
    wr_ena    = 1'b0;
    ctl_flush = 1'b1;
    step();
    ctl_flush = 1'b0;
    step();
    step();
    tests++; if (ctl_flush_busy !== 1'b1) begin fails++; $display("FAIL rstfl_busy got=%b exp=1", ctl_flush_busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (ctl_lvl !== 9'd0 || rd_empty !== 1'b1 || ctl_flush_busy !== 1'b0) begin
      fails++; $display("FAIL rstfl_state lvl=%0d empty=%b busy=%b exp 0 1 0", ctl_lvl, rd_empty, ctl_flush_busy);
    end
    tests++; if ({err_ovf, err_udf} !== 2'b00) begin fails++; $display("FAIL rstfl_err got=%b%b exp=00", err_ovf, err_udf); end
  endtask

  task automatic test_random();
    int pw, pr;
    for (int ph = 0; ph < 8; ph++) begin
      pw = $urandom_range(10, 95);
      pr = $urandom_range(10, 95);
      cfg_wm_hi = 9'($urandom_range(0, DEPTH + 2));
      cfg_wm_lo = 9'($urandom_range(0, DEPTH + 2));
      for (int c = 0; c < 250; c++) begin
        wr_ena    = ($urandom_range(0, 99) < pw);
        rd_ena    = ($urandom_range(0, 99) < pr);
        wr_data   = 16'($urandom);
        ctl_flush = ($urandom_range(0, 299) == 0);
        err_clr   = ($urandom_range(0, 49) == 0);
        step();
        tests++; if (ctl_lvl !== 9'(q.size()) || wr_full !== (q.size() == DEPTH) || rd_empty !== m_empty()) begin
          fails++; $display("FAIL rnd_level ph=%0d c=%0d lvl=%0d full=%b empty=%b exp lvl=%0d empty=%b", ph, c, ctl_lvl, wr_full, rd_empty, q.size(), m_empty());
        end
        if (!m_empty()) begin
          tests++; if (rd_data !== q[0].d) begin fails++; $display("FAIL rnd_data ph=%0d c=%0d got=%h exp=%h", ph, c, rd_data, q[0].d); end
        end
        tests++; if (irq_hi !== m_hi || irq_lo !== m_lo || ctl_flush_busy !== m_flush) begin
          fails++; $display("FAIL rnd_irq_busy ph=%0d c=%0d hi=%b lo=%b busy=%b exp %b %b %b", ph, c, irq_hi, irq_lo, ctl_flush_busy, m_hi, m_lo, m_flush);
        end
        tests++; if (err_ovf !== m_ovf || err_udf !== m_udf) begin
          fails++; $display("FAIL rnd_err ph=%0d c=%0d ovf=%b udf=%b exp %b %b", ph, c, err_ovf, err_udf, m_ovf, m_udf);
        end
      end
    end
    wr_ena    = 1'b0;
    rd_ena    = 1'b0;
    ctl_flush = 1'b0;
    err_clr   = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_word();
    test_fill_full();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_rst_in_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
